hdmi_src_sequencer: RTL and testbench

Shares the single llhdmi encoder between NSRC parallel 24-bit pixel sources, such as vgatestsrc instances running different patterns. It selects one source at a time and switches only on frame boundaries, optionally inserting black frames between sources. Advance is automatic after HOLD_FRAMES frames, or manual via a pulse. It sits between the source bank and llhdmi, in the pixel clock domain.

---
 rtl/hdmi_src_sequencer.sv | 139 +++++++++++++
 tb/tb_hdmi_src_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_src_sequencer.sv
// Frame-aligned selector sharing one llhdmi encoder between NSRC pixel sources, with optional black gap frames.
// Define SRC_INDEX_OVERLAY_EN to draw a white bar in the top 8 lines whose length encodes the source index.
module hdmi_src_sequencer #(
  parameter int NSRC         = 4,
  parameter int HOLD_FRAMES  = 120,
  parameter int BLANK_FRAMES = 1
) (
  input  logic                    i_pixclk,
  input  logic                    i_reset,
  input  logic                    i_rd,
  input  logic                    i_newline,
  input  logic                    i_newframe,
  input  logic                    i_next,
  input  logic                    i_auto,
  input  logic [NSRC*24-1:0]      i_src_pixel,
  output logic [23:0]             o_pixel,
  output logic [$clog2(NSRC)-1:0] o_sel,
  output logic                    o_blanking
);

  localparam int SELW = $clog2(NSRC);
  localparam int HW   = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int BW   = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
  localparam logic [SELW-1:0] SEL_LAST   = SELW'(NSRC - 1);
  localparam logic [HW-1:0]   HOLD_LAST  = HW'(HOLD_FRAMES - 1);
  localparam logic [BW-1:0]   BLANK_LAST = BW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

  typedef enum logic {ST_SHOW, ST_BLANK} state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d, sel_nxt;
  logic [HW-1:0]   hold_q, hold_d;
  logic [BW-1:0]   blank_q, blank_d;
  logic            pend_q, pend_d;
  logic [23:0]     pixel_q, pixel_d;
  logic            req, expire, overlay;

  always_ff @(posedge i_pixclk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_SHOW;
      sel_q   <= '0;
      hold_q  <= '0;
      blank_q <= '0;
      pend_q  <= 1'b0;
      pixel_q <= 24'h0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      blank_q <= blank_d;
      pend_q  <= pend_d;
      pixel_q <= pixel_d;
    end
  end

  // A request arriving on the boundary cycle itself is honoured at that boundary.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    blank_d = blank_q;
    pend_d  = pend_q;
    sel_nxt = (sel_q == SEL_LAST) ? '0 : sel_q + SELW'(1);
    req     = pend_q | i_next;
    expire  = i_auto && (hold_q == HOLD_LAST);
    case (state_q)
      ST_SHOW: begin
        pend_d = req;
        if (i_newframe) begin
          if (req || expire) begin
            hold_d = '0;
            pend_d = 1'b0;
            if (BLANK_FRAMES > 0) begin
              state_d = ST_BLANK;
              blank_d = '0;
            end else begin
              sel_d = sel_nxt;
            end
          end else if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      ST_BLANK: begin
        if (i_newframe) begin
          if (blank_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            sel_d   = sel_nxt;
          end else begin
            blank_d = blank_q + BW'(1);
          end
        end
      end
      default: state_d = ST_SHOW;
    endcase
  end

`ifdef SRC_INDEX_OVERLAY_EN
  logic [10:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;

  always_ff @(posedge i_pixclk or posedge i_reset) begin
    if (i_reset) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
    end else begin
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
    end
  end

  always_comb begin
    x_cnt_d = i_newline ? 11'd0 : (i_rd ? x_cnt_q + 11'd1 : x_cnt_q);
    y_cnt_d = i_newframe ? 11'd0 : (i_newline ? y_cnt_q + 11'd1 : y_cnt_q);
    overlay = (state_q == ST_SHOW) && (y_cnt_q < 11'd8) &&
              ({1'b0, x_cnt_q} < 12'(16 * (32'(sel_q) + 1)));
  end
`else
  logic unused_newline;
  assign unused_newline = i_newline;
  assign overlay        = 1'b0;
`endif

  always_comb begin
    pixel_d = pixel_q;
    if (i_rd) begin
      if (overlay)
        pixel_d = 24'hFFFFFF;
      else if (state_q == ST_BLANK)
        pixel_d = 24'h0;
      else
        pixel_d = i_src_pixel[24*sel_q +: 24];
    end
  end

  assign o_pixel    = pixel_q;
  assign o_sel      = sel_q;
  assign o_blanking = (state_q == ST_BLANK);

endmodule

// File: tb/tb_hdmi_src_sequencer.sv
// Randomized bench for hdmi_src_sequencer: two instances (one black gap frame / direct switch) against a frame-rule model.
module tb_hdmi_src_sequencer;

  localparam int NSRC      = 4;
  localparam int HOLD      = 3;
  localparam int LINE_LEN  = 40;
  localparam int FRAME_LEN = 10 * LINE_LEN;

  logic clk = 1'b0;
  logic rst, rd, nl, nf, nxt, autom;
  logic [23:0] src [NSRC];
  logic [NSRC*24-1:0] src_bus;
  logic [23:0] pix_o [2];
  logic [1:0]  sel_o [2];
  logic        blk_o [2];

  int n_checks = 0;
  int n_errors = 0;

  // model state, index 0 = one gap frame, index 1 = direct switch
  int        bfr [2] = '{1, 0};
  int        m_sel [2], m_hold [2], m_bcnt [2];
  bit        m_blank [2], m_pend [2];
  logic [23:0] m_pix [2];
  int        m_x, m_y;
  bit        const_src;

  always #5 clk = ~clk;

  always_comb begin
    src_bus = '0;
    for (int k = 0; k < NSRC; k++) src_bus[24*k +: 24] = src[k];
  end

  hdmi_src_sequencer #(.NSRC(NSRC), .HOLD_FRAMES(HOLD), .BLANK_FRAMES(1)) u_dut_gap (
    .i_pixclk(clk), .i_reset(rst), .i_rd(rd), .i_newline(nl), .i_newframe(nf),
    .i_next(nxt), .i_auto(autom), .i_src_pixel(src_bus),
    .o_pixel(pix_o[0]), .o_sel(sel_o[0]), .o_blanking(blk_o[0]));

  hdmi_src_sequencer #(.NSRC(NSRC), .HOLD_FRAMES(HOLD), .BLANK_FRAMES(0)) u_dut_dir (
    .i_pixclk(clk), .i_reset(rst), .i_rd(rd), .i_newline(nl), .i_newframe(nf),
    .i_next(nxt), .i_auto(autom), .i_src_pixel(src_bus),
    .o_pixel(pix_o[1]), .o_sel(sel_o[1]), .o_blanking(blk_o[1]));

  task automatic check_eq(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sel[k] = 0; m_hold[k] = 0; m_bcnt[k] = 0;
      m_blank[k] = 0; m_pend[k] = 0; m_pix[k] = 24'h0;
    end
    m_x = 0; m_y = 0;
  endtask

  // One clock of the frame-switching rules, evaluated on the inputs just driven.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rd) begin
        m_pix[k] = m_blank[k] ? 24'h0 : src[m_sel[k]];
`ifdef SRC_INDEX_OVERLAY_EN
        if (!m_blank[k] && m_y < 8 && m_x < 16 * (m_sel[k] + 1)) m_pix[k] = 24'hFFFFFF;
`endif
      end
      if (m_blank[k]) begin
        if (nf) begin
          if (m_bcnt[k] == bfr[k] - 1) begin
            m_blank[k] = 0;
            m_sel[k]   = (m_sel[k] + 1) % NSRC;
          end else m_bcnt[k]++;
        end
      end else if (nf) begin
        if (m_pend[k] || nxt || (autom && m_hold[k] == HOLD - 1)) begin
          m_hold[k] = 0;
          m_pend[k] = 0;
          if (bfr[k] > 0) begin m_blank[k] = 1; m_bcnt[k] = 0; end
          else m_sel[k] = (m_sel[k] + 1) % NSRC;
        end else if (m_hold[k] < HOLD - 1) m_hold[k]++;
      end else if (nxt) m_pend[k] = 1;
    end
    m_x = nl ? 0 : (rd ? (m_x + 1) & 2047 : m_x);
    m_y = nf ? 0 : (nl ? (m_y + 1) & 2047 : m_y);
  endtask

  task automatic cyc(bit c_rd, bit c_nl, bit c_nf, bit c_nxt);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("sel[%0d]", k), 32'(sel_o[k]), 32'(m_sel[k]));
      check_eq($sformatf("blanking[%0d]", k), 32'(blk_o[k]), 32'(m_blank[k]));
      check_eq($sformatf("pixel[%0d]", k), 32'(pix_o[k]), 32'(m_pix[k]));
    end
    rd = c_rd; nl = c_nl; nf = c_nf; nxt = c_nxt;
    for (int k = 0; k < NSRC; k++)
      src[k] = const_src ? 24'h111111 * 24'(k + 1) : 24'($urandom);
    model_step();
  endtask

  task automatic frame(int p1, int p2, bit rand_nxt);
    for (int c = 0; c < FRAME_LEN; c++) begin
      bit c_rd = ($urandom_range(3) != 0) || (c == FRAME_LEN - 1);
      bit c_nx = (c == p1) || (c == p2) || (rand_nxt && $urandom_range(63) == 0);
      cyc(c_rd, (c % LINE_LEN) == 0, c == 0, c_nx);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted between clock edges; outputs must clear before any edge.
  task automatic async_reset(string tag);
    @(posedge clk);
    #3;
    rst = 1'b1; rd = 0; nl = 0; nf = 0; nxt = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("%s_sel[%0d]", tag, k), 32'(sel_o[k]), 32'd0);
      check_eq($sformatf("%s_blank[%0d]", tag, k), 32'(blk_o[k]), 32'd0);
      check_eq($sformatf("%s_pix[%0d]", tag, k), 32'(pix_o[k]), 32'd0);
    end
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd = 0; nl = 0; nf = 0; nxt = 0; autom = 0;
    const_src = 1;
    for (int k = 0; k < NSRC; k++) src[k] = 24'h111111 * 24'(k + 1);
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_sel", 32'(sel_o[0]), 32'd0);
    check_eq("rst_blank", 32'(blk_o[0]), 32'd0);
    check_eq("rst_pix", 32'(pix_o[0]), 32'd0);
    rst = 1'b0;

    // constant patterns, manual mode
    frame(-1, -1, 0);
    frame(-1, -1, 0);
    settle();
    check_eq("const_pix", 32'(pix_o[0]), 32'h111111);

    // manual request mid-frame
    frame(10, -1, 0);
    frame(-1, -1, 0);
    settle();
    check_eq("gap_blanking", 32'(blk_o[0]), 32'd1);
    check_eq("gap_pix_black", 32'(pix_o[0]), 32'd0);
    check_eq("dir_sel_after_next", 32'(sel_o[1]), 32'd1);
    frame(-1, -1, 0);
    settle();
    check_eq("gap_sel_after_blank", 32'(sel_o[0]), 32'd1);
    check_eq("gap_blank_done", 32'(blk_o[0]), 32'd0);
    check_eq("gap_pix_src1", 32'(pix_o[0]), 32'h222222);

    // request on the boundary cycle, then request while blanking
    async_reset("rst_a");
    frame(0, 5, 0);
    settle();
    check_eq("same_cycle_gap_blank", 32'(blk_o[0]), 32'd1);
    check_eq("same_cycle_dir_sel", 32'(sel_o[1]), 32'd1);
    frame(-1, -1, 0);
    frame(-1, -1, 0);
    settle();
    check_eq("blank_next_ignored_sel", 32'(sel_o[0]), 32'd1);
    check_eq("blank_next_ignored_blk", 32'(blk_o[0]), 32'd0);
    check_eq("dir_pending_sel", 32'(sel_o[1]), 32'd2);

    // auto mode from reset: direct instance changes every 3 boundaries and wraps
    async_reset("rst_b");
    const_src = 0;
    autom = 1;
    for (int f = 0; f < 11; f++) frame(-1, -1, 0);
    settle();
    check_eq("auto_dir_sel11", 32'(sel_o[1]), 32'd3);
    check_eq("auto_gap_blk11", 32'(blk_o[0]), 32'd1);
    check_eq("auto_gap_sel11", 32'(sel_o[0]), 32'd2);
    frame(-1, -1, 0);
    settle();
    check_eq("auto_dir_wrap", 32'(sel_o[1]), 32'd0);
    check_eq("auto_gap_sel12", 32'(sel_o[0]), 32'd3);

    // freeze then resume auto, then random mix
    autom = 0;
    frame(-1, -1, 0);
    frame(-1, -1, 0);
    autom = 1;
    for (int f = 0; f < 24; f++) begin
      autom = ($urandom_range(3) != 0);
      frame(($urandom_range(3) == 0) ? 0 : -1, -1, 1);
    end

    // reach BLANK with sel=2 on the gap instance, then reset mid-frame
    autom = 0;
    begin
      bit hit = 0;
      for (int f = 0; f < 20 && !hit; f++) begin
        frame(5, -1, 0);
        hit = m_blank[0] && (m_sel[0] == 2);
      end
      settle();
      check_eq("reach_blank_sel2", {29'd0, blk_o[0], sel_o[0]}, 32'h6);
    end
    async_reset("rst_blank");
    frame(-1, -1, 0);
    frame(-1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
